// File: rtl/moore_seq_detector_1011.sv
// ---------------------------------------------------------------------------
// moore_seq_detector_1011
//
// Moore-type serial pattern detector for the bit sequence 1-0-1-1.
// One bit is sampled from seq_in on every rising clock edge. When the fourth
// bit of a complete pattern is sampled, detect_out goes high for exactly one
// cycle. Detection is non-overlapping: once a pattern has been reported, none
// of its bits can contribute to the next detection.
//
// Ports:
//   clk        in   1  single clock, all state updates on its rising edge
//   reset      in   1  asynchronous, active-high; forces IDLE and clears
//                      detect_out immediately
//   seq_in     in   1  serial data bit, must be stable around the rising edge
//   detect_out out  1  registered Moore output, high while the FSM is in DET
// ---------------------------------------------------------------------------
module moore_seq_detector_1011 (
    input  logic clk,
    input  logic reset,
    input  logic seq_in,
    output logic detect_out
);

    // One-hot state encoding. Each state records the longest prefix of 1011
    // that is still a live partial match, with DET meaning "just completed".
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        S1   = 5'b00010,
        S10  = 5'b00100,
        S101 = 5'b01000,
        DET  = 5'b10000
    } state_t;

    state_t state;
    state_t next_state;
    logic   detect_next;

    // State register. Reset is asynchronous so a partial match is discarded
    // the moment reset rises, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Two transitions deserve a note:
    //   S101 on 0 falls back to S10, because the trailing "10" is still a
    //   valid start of a new pattern.
    //   DET on 1 goes to S1 rather than continuing the old match: the last 1
    //   of the reported pattern is consumed, so only the fresh 1 counts.
    // Any code that is not one of the five one-hot values drops to IDLE.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = seq_in ? S1   : IDLE;
            S1:      next_state = seq_in ? S1   : S10;
            S10:     next_state = seq_in ? S101 : IDLE;
            S101:    next_state = seq_in ? DET  : S10;
            DET:     next_state = seq_in ? S1   : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode. It looks one state ahead so that the registered output
    // lines up exactly with the cycle in which state == DET.
    always_comb begin
        detect_next = 1'b0;
        if (next_state == DET) begin
            detect_next = 1'b1;
        end
    end

    // Output register. Keeping detect_out in a flop means it never depends
    // combinationally on seq_in, and reset clears it together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            detect_out <= 1'b0;
        end else begin
            detect_out <= detect_next;
        end
    end

endmodule

// File: tb/tb_moore_seq_detector_1011.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detector_1011
//
// Self-checking bench for moore_seq_detector_1011. The reference model keeps
// the bits seen since the last detection or reset and reports a hit when the
// most recent four of them read 1,0,1,1. After a hit the history is emptied,
// so no bit of a reported pattern is ever reused.
// ---------------------------------------------------------------------------
module tb_moore_seq_detector_1011;

    logic clk;
    logic reset;
    logic seq_in;
    logic detect_out;

    int compared_cnt;
    int mismatch_cnt;

    // Bits received since the last detection or reset, oldest first
    logic history[$];

    moore_seq_detector_1011 dut (
        .clk        (clk),
        .reset      (reset),
        .seq_in     (seq_in),
        .detect_out (detect_out)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if observed and expected differ
    task automatic checkOutput(input string tag, input logic [4:0] observed,
                               input logic [4:0] expected);
        compared_cnt++;
        if (observed !== expected) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b",
                     tag, $time, observed, expected);
        end
    endtask

    // Advance the reference model by one sampled bit and return whether this
    // bit completes a 1011 pattern
    function automatic logic modelStep(input logic b);
        logic hit;
        hit = 1'b0;
        history.push_back(b);
        if (history.size() > 4) begin
            void'(history.pop_front());
        end
        if (history.size() == 4 &&
            history[0] == 1'b1 && history[1] == 1'b0 &&
            history[2] == 1'b1 && history[3] == 1'b1) begin
            hit = 1'b1;
            history.delete();
        end
        return hit;
    endfunction

    // Drive one bit, let the DUT sample it, then compare detect_out against
    // the model shortly after the edge
    task automatic applyStimulus(input string tag, input logic b);
        logic expected;
        seq_in = b;
        @(posedge clk);
        #1;
        expected = modelStep(b);
        checkOutput(tag, {4'b0, detect_out}, {4'b0, expected});
    endtask

    // Pulse reset between edges; detect_out must clear without any clock
    task automatic pulseReset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput(tag, {4'b0, detect_out}, 5'b0);
        history.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Run a short directed bit sequence through the model-checked path
    task automatic applySequence(input string tag, input logic bits[$]);
        foreach (bits[i]) begin
            applyStimulus(tag, bits[i]);
        end
    endtask

    // Main stimulus: directed scenarios first, then a long random stream
    initial begin
        compared_cnt = 0;
        mismatch_cnt = 0;
        reset  = 1'b1;
        seq_in = 1'b0;

        // Reset held for two edges: IDLE and detect_out low throughout
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_out", {4'b0, detect_out}, 5'b0);
            checkOutput("reset_state", 5'(dut.state), 5'b00001);
        end
        @(negedge clk);
        reset = 1'b0;

        // Single pattern followed by a trailing zero
        applySequence("single", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0});

        // Non-overlap: bits 4..7 would form 1011 only if bit 4 were reused
        pulseReset("clr1");
        applySequence("nonoverlap", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});

        // Back-to-back patterns, pulses after bits 4 and 8
        pulseReset("clr2");
        applySequence("backtoback",
                      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});

        // Partial-match fallback cases
        pulseReset("clr3");
        applySequence("fallback_a", '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        pulseReset("clr4");
        applySequence("fallback_b", '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});

        // Reset mid-sequence discards the partial match
        pulseReset("clr5");
        applySequence("mid_pre", '{1'b1, 1'b0, 1'b1});
        pulseReset("mid_reset");
        applySequence("mid_post", '{1'b1});
        applySequence("mid_finish", '{1'b0, 1'b1, 1'b1});

        // Asynchronous reset while the pulse is high must drop it mid-cycle
        pulseReset("clr6");
        applySequence("async_pre", '{1'b1, 1'b0, 1'b1, 1'b1});
        checkOutput("async_high", {4'b0, detect_out}, 5'b00001);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_drop", {4'b0, detect_out}, 5'b0);
        checkOutput("async_state", 5'(dut.state), 5'b00001);
        history.delete();
        @(negedge clk);
        reset = 1'b0;

        // Constant streams never detect
        for (int i = 0; i < 20; i++) applyStimulus("all_zero", 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus("all_one", 1'b1);

        // Random stream with occasional resets; a bias toward 1 makes
        // complete patterns reasonably frequent
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset("rand_reset");
            end else begin
                applyStimulus("random", ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
